// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_pkg
// Brief    : Shared bus widths, access-mode codes and arbiter state encoding.
// Revision : 1.0
// ============================================================================
package bus_pkg;

  localparam int XLEN        = 32;
  localparam int SLAVE_WIDTH = 4;
  localparam int BUS_ADDR_W  = XLEN - SLAVE_WIDTH;

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_if
// Brief    : Per-master request bundle plus the shared slave-side bus.
// Revision : 1.0
// ============================================================================
import bus_pkg::*;

interface bus_arbiter_if #(
  parameter int N_MASTERS = 2
);

  logic [N_MASTERS-1:0]             m_req;
  logic [N_MASTERS-1:0]             m_wen;
  logic [3*N_MASTERS-1:0]           m_mode;
  logic [BUS_ADDR_W*N_MASTERS-1:0]  m_addr;
  logic [SLAVE_WIDTH*N_MASTERS-1:0] m_num;
  logic [XLEN*N_MASTERS-1:0]        m_dat_o;
  logic [XLEN-1:0]                  m_dat_i;
  logic [N_MASTERS-1:0]             m_ready;
  logic [N_MASTERS-1:0]             m_err;

  logic                             bus_req;
  logic                             bus_wen;
  logic [2:0]                       bus_mode;
  logic [BUS_ADDR_W-1:0]            bus_addr;
  logic [SLAVE_WIDTH-1:0]           bus_num;
  logic [XLEN-1:0]                  bus_dat_o;
  logic [XLEN-1:0]                  bus_dat_i;
  logic                             bus_ready;

  // The arbiter: serves the masters and drives the interconnect.
  modport slave (
    input  m_req, m_wen, m_mode, m_addr, m_num, m_dat_o, bus_dat_i, bus_ready,
    output m_dat_i, m_ready, m_err,
    output bus_req, bus_wen, bus_mode, bus_addr, bus_num, bus_dat_o
  );

  // The surrounding system: requesting masters and the slave interconnect.
  modport master (
    output m_req, m_wen, m_mode, m_addr, m_num, m_dat_o, bus_dat_i, bus_ready,
    input  m_dat_i, m_ready, m_err,
    input  bus_req, bus_wen, bus_mode, bus_addr, bus_num, bus_dat_o
  );

endinterface
`default_nettype wire

// File: rtl/bus_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Brief    : Combinational round-robin selector (rotate + priority encode).
// Revision : 1.0
// ============================================================================
module rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] sel
);

  logic [IDX_W-1:0] w_start;
  logic [2*N-1:0]   w_dbl;
  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_off;
  logic [IDX_W:0]   w_sum;

  always_comb begin
    w_start = (int'(last) == N - 1) ? '0 : last + 1'b1;
    w_dbl   = {req, req};
    // Bit 0 of the rotated vector is the requester just after the last winner.
    w_rot   = w_dbl[w_start +: N];
    valid   = |req;
    w_off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = IDX_W'(i);
      end
    end
    w_sum = {1'b0, w_start} + {1'b0, w_off};
    sel   = (int'(w_sum) >= N) ? IDX_W'(int'(w_sum) - N) : w_sum[IDX_W-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Brief    : Round-robin system bus arbiter with transfer timeout.
// Revision : 1.0
// ============================================================================
import bus_pkg::*;

module bus_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input logic          clk,
  input logic          rst,
  bus_arbiter_if.slave bif
);

  localparam int c_IDX_W = $clog2(N_MASTERS);

  arb_state_t           r_state;
  logic [c_IDX_W-1:0]   r_grant;
  logic [c_IDX_W-1:0]   r_last;
  logic [CNT_W-1:0]     r_tcnt;

  logic                 w_pick_valid;
  logic [c_IDX_W-1:0]   w_pick_sel;
  logic                 w_active;
  logic                 w_timeout;
  logic                 w_done;
  logic [N_MASTERS-1:0] w_grant_oh;

  rr_picker #(
    .N     (N_MASTERS),
    .IDX_W (c_IDX_W)
  ) u_picker (
    .req   (bif.m_req),
    .last  (r_last),
    .valid (w_pick_valid),
    .sel   (w_pick_sel)
  );

  // A granted master that drops its request aborts the transfer immediately.
  assign w_active   = (r_state == ARB_BUSY) && !rst && bif.m_req[r_grant];
  assign w_grant_oh = {{(N_MASTERS-1){1'b0}}, 1'b1} << r_grant;

  generate
    if (TIMEOUT > 0) begin : g_timeout
      assign w_timeout = w_active && !bif.bus_ready &&
                         (r_tcnt == CNT_W'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  assign w_done = w_active && (bif.bus_ready || w_timeout);

  always_comb begin
    bif.m_ready   = w_done    ? w_grant_oh : '0;
    bif.m_err     = w_timeout ? w_grant_oh : '0;
    bif.m_dat_i   = (w_active && !w_timeout) ? bif.bus_dat_i : '0;
    bif.bus_req   = w_active;
    bif.bus_wen   = 1'b0;
    bif.bus_mode  = '0;
    bif.bus_addr  = '0;
    bif.bus_num   = '0;
    bif.bus_dat_o = '0;
    if (w_active) begin
      bif.bus_wen   = bif.m_wen[r_grant];
      bif.bus_mode  = bif.m_mode[int'(r_grant)*3 +: 3];
      bif.bus_addr  = bif.m_addr[int'(r_grant)*BUS_ADDR_W +: BUS_ADDR_W];
      bif.bus_num   = bif.m_num[int'(r_grant)*SLAVE_WIDTH +: SLAVE_WIDTH];
      bif.bus_dat_o = bif.m_dat_o[int'(r_grant)*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_last  <= c_IDX_W'(N_MASTERS - 1);
      r_tcnt  <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          r_tcnt <= '0;
          if (w_pick_valid) begin
            r_grant <= w_pick_sel;
            r_state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (!bif.m_req[r_grant] || w_done) begin
            r_state <= ARB_IDLE;
            r_last  <= r_grant;
            r_tcnt  <= '0;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Brief    : Directed self-checking bench for bus_arbiter (2 masters, TIMEOUT=8).
// Revision : 1.0
// ============================================================================
import bus_pkg::*;

module tb_bus_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bus_arbiter_if #(.N_MASTERS(2)) bif ();

  bus_arbiter #(
    .N_MASTERS (2),
    .TIMEOUT   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst            = 1'b1;
    bif.m_req      = 2'b00;
    bif.m_wen      = 2'b10;
    bif.m_mode     = {MODE_W, MODE_BU};
    bif.m_addr     = {28'h0000234, 28'h0000010};
    bif.m_num      = {4'd2, 4'd1};
    bif.m_dat_o    = {32'hCAFEF00D, 32'h11112222};
    bif.bus_dat_i  = 32'h0;
    bif.bus_ready  = 1'b0;

    // Reset and idle
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_bus_req", 64'(bif.bus_req), 64'h0);
    chk("reset_m_ready", 64'(bif.m_ready), 64'h0);
    chk("reset_m_err", 64'(bif.m_err), 64'h0);
    chk("reset_bus_addr", 64'(bif.bus_addr), 64'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_bus_req", 64'(bif.bus_req), 64'h0);
      chk("idle_m_ready", 64'(bif.m_ready), 64'h0);
    end

    // Single read from master 0, ready on the 2nd BUSY cycle
    bif.m_req = 2'b01;
    #1;
    chk("t2_arb_bus_req", 64'(bif.bus_req), 64'h0);
    tick();
    chk("t2_busy_bus_req", 64'(bif.bus_req), 64'h1);
    chk("t2_bus_addr", 64'(bif.bus_addr), 64'h10);
    chk("t2_bus_num", 64'(bif.bus_num), 64'h1);
    chk("t2_bus_wen", 64'(bif.bus_wen), 64'h0);
    chk("t2_bus_mode", 64'(bif.bus_mode), 64'(MODE_BU));
    chk("t2_no_ready", 64'(bif.m_ready), 64'h0);
    tick();
    bif.bus_ready = 1'b1;
    bif.bus_dat_i = 32'hDEADBEEF;
    #1;
    chk("t2_m_ready", 64'(bif.m_ready), 64'h1);
    chk("t2_m_dat_i", 64'(bif.m_dat_i), 64'hDEADBEEF);
    chk("t2_m_err", 64'(bif.m_err), 64'h0);
    tick();
    bif.m_req     = 2'b00;
    bif.bus_ready = 1'b0;
    #1;
    chk("t2_after_bus_req", 64'(bif.bus_req), 64'h0);
    chk("t2_after_m_ready", 64'(bif.m_ready), 64'h0);

    // Both masters held, slave always ready: grants alternate starting at 0
    rst = 1'b1;
    tick();
    rst           = 1'b0;
    bif.m_req     = 2'b11;
    bif.bus_ready = 1'b1;
    bif.bus_dat_i = 32'h0BADF00D;
    #1;
    chk("t3_idle_bus_req", 64'(bif.bus_req), 64'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_busy_bus_req", 64'(bif.bus_req), 64'h1);
      chk("t3_m_ready", 64'(bif.m_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      chk("t3_m_dat_i", 64'(bif.m_dat_i), 64'h0BADF00D);
      tick();
      chk("t3_gap_bus_req", 64'(bif.bus_req), 64'h0);
      chk("t3_gap_m_ready", 64'(bif.m_ready), 64'h0);
    end

    // Timeout on master 1 with the slave stuck
    bif.m_req     = 2'b10;
    bif.bus_ready = 1'b0;
    bif.bus_dat_i = 32'h55AA55AA;
    #1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk("t4_wait_bus_req", 64'(bif.bus_req), 64'h1);
      chk("t4_wait_m_ready", 64'(bif.m_ready), 64'h0);
    end
    chk("t4_bus_wen", 64'(bif.bus_wen), 64'h1);
    chk("t4_bus_dat_o", 64'(bif.bus_dat_o), 64'hCAFEF00D);
    tick();
    chk("t4_to_m_ready", 64'(bif.m_ready), 64'h2);
    chk("t4_to_m_err", 64'(bif.m_err), 64'h2);
    chk("t4_to_m_dat_i", 64'(bif.m_dat_i), 64'h0);
    tick();
    chk("t4_post_bus_req", 64'(bif.bus_req), 64'h0);
    chk("t4_post_m_err", 64'(bif.m_err), 64'h0);

    // Ready coinciding with the timeout cycle: ready wins, no error
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk("t4b_wait_m_ready", 64'(bif.m_ready), 64'h0);
    end
    tick();
    bif.bus_ready = 1'b1;
    bif.bus_dat_i = 32'h12345678;
    #1;
    chk("t4b_m_ready", 64'(bif.m_ready), 64'h2);
    chk("t4b_m_err", 64'(bif.m_err), 64'h0);
    chk("t4b_m_dat_i", 64'(bif.m_dat_i), 64'h12345678);
    tick();
    bif.m_req     = 2'b11;
    bif.bus_ready = 1'b0;
    #1;

    // Master 0 aborts mid-transfer; master 1 follows after one IDLE cycle
    chk("t5_idle_bus_req", 64'(bif.bus_req), 64'h0);
    tick();
    chk("t5_busy_bus_req", 64'(bif.bus_req), 64'h1);
    chk("t5_busy_addr", 64'(bif.bus_addr), 64'h10);
    tick();
    bif.m_req = 2'b10;
    #1;
    chk("t5_abort_bus_req", 64'(bif.bus_req), 64'h0);
    chk("t5_abort_m_ready", 64'(bif.m_ready), 64'h0);
    chk("t5_abort_addr", 64'(bif.bus_addr), 64'h0);
    tick();
    chk("t5_gap_bus_req", 64'(bif.bus_req), 64'h0);
    tick();
    bif.bus_ready = 1'b1;
    bif.bus_dat_i = 32'h0000BEEF;
    #1;
    chk("t5_m1_bus_req", 64'(bif.bus_req), 64'h1);
    chk("t5_m1_addr", 64'(bif.bus_addr), 64'h234);
    chk("t5_m1_num", 64'(bif.bus_num), 64'h2);
    chk("t5_m1_mode", 64'(bif.bus_mode), 64'(MODE_W));
    chk("t5_m1_m_ready", 64'(bif.m_ready), 64'h2);
    tick();
    bif.m_req     = 2'b01;
    bif.bus_ready = 1'b0;
    #1;

    // Reset during BUSY, then master 0 is granted again
    chk("t6_idle_bus_req", 64'(bif.bus_req), 64'h0);
    tick();
    chk("t6_busy_bus_req", 64'(bif.bus_req), 64'h1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_rst_bus_req", 64'(bif.bus_req), 64'h0);
    chk("t6_rst_m_ready", 64'(bif.m_ready), 64'h0);
    chk("t6_rst_bus_addr", 64'(bif.bus_addr), 64'h0);
    tick();
    bif.bus_ready = 1'b1;
    bif.bus_dat_i = 32'h0000A5A5;
    #1;
    chk("t6_regrant_bus_req", 64'(bif.bus_req), 64'h1);
    chk("t6_regrant_addr", 64'(bif.bus_addr), 64'h10);
    chk("t6_regrant_m_ready", 64'(bif.m_ready), 64'h1);
    chk("t6_regrant_m_dat_i", 64'(bif.m_dat_i), 64'hA5A5);
    tick();
    bif.m_req     = 2'b00;
    bif.bus_ready = 1'b0;
    #1;
    chk("t6_end_bus_req", 64'(bif.bus_req), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
